// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared constants, FSM state type and access-size helper for the memory stage.
package rv_mem_pkg;
    localparam int XLEN = 64;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_e;

    function automatic logic [3:0] size_of(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction
endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory request/grant/read-return handshake.
interface mem_access_unit_if;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;

    modport master (output req, we, addr, wdata, wstrb, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane placement of store data/strobes and extraction plus extension of load data.
module mem_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]        off,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   store_data,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wdata,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   load_data
);
    logic [XLEN-1:0] sh;
    logic [7:0]      mask;
    logic            sx;

    always_comb begin
        mask = 8'((16'd1 << size_of(funct3)) - 16'd1);
        wdata = store_data << {off, 3'b000};
        wstrb = mask << off;
        sh = rdata >> {off, 3'b000};
        sx = ~funct3[2];
        load_data = funct3[1:0] == F3_LB[1:0] ? {{56{sx & sh[7]}}, sh[7:0]} :
                    funct3[1:0] == F3_LH[1:0] ? {{48{sx & sh[15]}}, sh[15:0]} :
                    funct3[1:0] == F3_LW[1:0] ? {{32{sx & sh[31]}}, sh[31:0]} : sh;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store FSM driving a variable-latency data-memory handshake.
module mem_access_unit
  import rv_mem_pkg::*;
#(parameter int TIMEOUT = 255)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pipeline_en,
  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_storeData,
  mem_access_unit_if.master bus,
  output logic              mem_stall,
  output logic [XLEN-1:0]   me_outMem,
  output logic              me_misalign,
  output logic              me_timeout
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] out_q, out_d, load_data;
  logic            mis_q, mis_d, to_q, to_d;
  logic            access, is_write, bad, expired;
  logic [2:0]      off;
  assign off = ex_addr[2:0];
  assign access = ex_memRead | ex_memWrite;
  assign is_write = ex_memWrite & ~ex_memRead;
  assign bad = ex_funct3 == F3_ILL || (is_write && ex_funct3[2]) ||
               (off & 3'(size_of(ex_funct3) - 4'd1)) != 3'd0;
  mem_lane_align u_align (
    .off        (off),
    .funct3     (ex_funct3),
    .store_data (ex_storeData),
    .rdata      (bus.rdata),
    .wdata      (bus.wdata),
    .wstrb      (bus.wstrb),
    .load_data  (load_data)
  );
  assign bus.req = state_q == REQ;
  assign bus.we = bus.req & is_write;
  assign bus.addr = {ex_addr[XLEN-1:3], 3'b000};
  assign mem_stall = state_q == REQ || state_q == WAIT_R || (state_q == IDLE && access);
  assign me_outMem = out_q;
  assign me_misalign = mis_q;
  assign me_timeout = to_q;
`ifdef MEM_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (state_q == REQ || state_q == WAIT_R) ? cnt_q + 16'd1 : '0;
  assign expired = cnt_q == 16'(TIMEOUT - 1);
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    out_d = out_q;
    mis_d = mis_q;
    to_d = to_q;
    case (state_q)
      IDLE: if (access) begin
        state_d = bad ? DONE : REQ;
        mis_d = bad;
        to_d = 1'b0;
        out_d = bad ? '0 : out_q;
      end
      REQ: if (bus.gnt) begin
        state_d = is_write ? DONE : WAIT_R;
        out_d = is_write ? '0 : out_q;
      end else if (expired) begin
        state_d = DONE;
        to_d = 1'b1;
        out_d = '0;
      end
      WAIT_R: if (bus.rvalid) begin
        state_d = DONE;
        out_d = load_data;
      end else if (expired) begin
        state_d = DONE;
        to_d = 1'b1;
        out_d = '0;
      end
      DONE: state_d = pipeline_en ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      out_q <= '0;
      mis_q <= 1'b0;
      to_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      mis_q <= mis_d;
      to_q <= to_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store accesses checked against a byte-level model.
module tb_mem_access_unit;
  logic        clk = 1'b0, rst = 1'b1, pipeline_en = 1'b0;
  logic        ex_memRead = 1'b0, ex_memWrite = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [63:0] ex_addr = '0, ex_storeData = '0;
  logic        mem_stall, me_misalign, me_timeout;
  logic [63:0] me_outMem;
  int          vectors = 0, errors = 0;
  int          obs_stall, obs_req, obs_hold_bad;
  logic        obs_we, obs_mis, obs_to;
  logic [63:0] obs_addr, obs_wdata, obs_out, obs_out0;
  logic [7:0]  obs_wstrb;

  mem_access_unit_if bus();

  mem_access_unit #(.TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipeline_en  (pipeline_en),
    .ex_memRead   (ex_memRead),
    .ex_memWrite  (ex_memWrite),
    .ex_funct3    (ex_funct3),
    .ex_addr      (ex_addr),
    .ex_storeData (ex_storeData),
    .bus          (bus),
    .mem_stall    (mem_stall),
    .me_outMem    (me_outMem),
    .me_misalign  (me_misalign),
    .me_timeout   (me_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] rdata);
    int n = 1 << f3[1:0];
    int off = int'(addr[2:0]);
    logic [63:0] v = '0;
    for (int i = 0; i < 8; i++)
      if (i < n) v[8*i +: 8] = rdata[8*(off+i) +: 8];
      else if (!f3[2] && v[8*n-1]) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic model_bad(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] addr);
    int n = 1 << f3[1:0];
    return f3 == 3'b111 || (wr && !rd && f3[2]) || (int'(addr[2:0]) % n != 0);
  endfunction

  function automatic logic [7:0] model_wstrb(input logic [2:0] f3, input logic [63:0] addr);
    int n = 1 << f3[1:0];
    int off = int'(addr[2:0]);
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) s[i] = i >= off && i < off + n;
    return s;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] addr, input logic [63:0] sdata);
    int off = int'(addr[2:0]);
    logic [63:0] d = '0;
    for (int i = 0; i < 8; i++) if (i >= off) d[8*i +: 8] = sdata[8*(i-off) +: 8];
    return d;
  endfunction

  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] sdata, input logic [63:0] rdata,
                            input int gnt_dly, input int rv_dly, input int pe_hold);
    bit granted = 0, fin = 0;
    int since_gnt = 0;
    obs_stall = 0; obs_req = 0; obs_hold_bad = 0;
    obs_we = 0; obs_addr = '0; obs_wdata = '0; obs_wstrb = '0;
    @(negedge clk);
    ex_memRead = rd; ex_memWrite = wr; ex_funct3 = f3; ex_addr = addr; ex_storeData = sdata;
    pipeline_en = 1'b0; bus.rdata = rdata;
    repeat (200) begin
      #1;
      if (!mem_stall) begin fin = 1; break; end
      obs_stall++;
      if (granted) since_gnt++;
      bus.rvalid = granted && since_gnt == rv_dly;
      bus.gnt = bus.req && obs_req == gnt_dly;
      if (bus.req) obs_req++;
      if (bus.gnt) begin
        granted = 1; since_gnt = 0;
        obs_we = bus.we; obs_addr = bus.addr; obs_wdata = bus.wdata; obs_wstrb = bus.wstrb;
      end
      @(negedge clk);
      bus.gnt = 1'b0; bus.rvalid = 1'b0;
    end
    vectors++;
    if (!fin) begin errors++; $display("FAIL access_bound: stall never released for addr %h", addr); end
    obs_mis = me_misalign; obs_to = me_timeout; obs_out0 = me_outMem;
    repeat (pe_hold) begin
      @(negedge clk); #1;
      if (bus.req || mem_stall || me_outMem !== obs_out0) obs_hold_bad++;
    end
    pipeline_en = 1'b1;
    obs_out = me_outMem;
    @(negedge clk);
    ex_memRead = 1'b0; ex_memWrite = 1'b0; pipeline_en = 1'b0;
  endtask

  task automatic test_reset;
    bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors += 5;
    if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", mem_stall); end
    if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", bus.req); end
    if (me_outMem !== 64'd0) begin errors++; $display("FAIL reset_out: got %h want 0", me_outMem); end
    if (me_misalign !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", me_misalign); end
    if (me_timeout !== 1'b0) begin errors++; $display("FAIL reset_to: got %b want 0", me_timeout); end
    rst = 1'b0;
  endtask

  task automatic test_lb;
    run_access(1, 0, 3'b000, 64'h1003, '0, 64'h0000_80FF_0000_0000, 0, 1, 0);
    vectors += 3;
    if (obs_addr !== 64'h1000) begin errors++; $display("FAIL lb_addr: got %h want 1000", obs_addr); end
    if (obs_out !== 64'd0) begin errors++; $display("FAIL lb_zero: got %h want 0", obs_out); end
    if (obs_stall !== 3) begin errors++; $display("FAIL lb_stall: got %0d want 3", obs_stall); end
    run_access(1, 0, 3'b000, 64'h1003, '0, 64'h0000_80FF_8000_0000, 0, 1, 0);
    vectors++;
    if (obs_out !== 64'hFFFF_FFFF_FFFF_FF80) begin errors++; $display("FAIL lb_sext: got %h want ffffffffffffff80", obs_out); end
    run_access(1, 0, 3'b100, 64'h1003, '0, 64'h0000_80FF_8000_0000, 0, 1, 0);
    vectors++;
    if (obs_out !== 64'h80) begin errors++; $display("FAIL lbu_zext: got %h want 80", obs_out); end
  endtask

  task automatic test_sh;
    run_access(0, 1, 3'b001, 64'h2006, 64'hABCD, '0, 0, 1, 0);
    vectors += 5;
    if (obs_wstrb !== 8'hC0) begin errors++; $display("FAIL sh_wstrb: got %h want c0", obs_wstrb); end
    if (obs_wdata[63:48] !== 16'hABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcd", obs_wdata[63:48]); end
    if (obs_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b want 1", obs_we); end
    if (obs_stall !== 2) begin errors++; $display("FAIL sh_stall: got %0d want 2", obs_stall); end
    if (obs_out !== 64'd0) begin errors++; $display("FAIL sh_out: got %h want 0", obs_out); end
  endtask

  task automatic test_misalign;
    run_access(1, 0, 3'b010, 64'h3002, '0, 64'hDEAD_BEEF_1234_5678, 0, 1, 0);
    vectors += 4;
    if (obs_mis !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", obs_mis); end
    if (obs_req !== 0) begin errors++; $display("FAIL mis_req: got %0d req cycles want 0", obs_req); end
    if (obs_out !== 64'd0) begin errors++; $display("FAIL mis_out: got %h want 0", obs_out); end
    if (obs_stall !== 1) begin errors++; $display("FAIL mis_stall: got %0d want 1", obs_stall); end
  endtask

  task automatic test_ld_delayed;
    run_access(1, 0, 3'b011, 64'h4000, '0, 64'h0123_4567_89AB_CDEF, 3, 2, 4);
    vectors += 5;
    if (obs_req !== 4) begin errors++; $display("FAIL ld_req: got %0d req cycles want 4", obs_req); end
    if (obs_stall !== 7) begin errors++; $display("FAIL ld_stall: got %0d want 7", obs_stall); end
    if (obs_out !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL ld_out: got %h want 0123456789abcdef", obs_out); end
    if (obs_hold_bad !== 0) begin errors++; $display("FAIL ld_hold: got %0d bad DONE cycles want 0", obs_hold_bad); end
    if (obs_mis !== 1'b0) begin errors++; $display("FAIL ld_mis: got %b want 0", obs_mis); end
  endtask

  task automatic test_reset_midaccess;
    @(negedge clk);
    ex_memRead = 1'b1; ex_funct3 = 3'b011; ex_addr = 64'h4008; bus.rdata = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk); #1;
    bus.gnt = bus.req;
    @(negedge clk);
    bus.gnt = 1'b0; #1;
    vectors += 2;
    if (mem_stall !== 1'b1) begin errors++; $display("FAIL rstmid_wait_stall: got %b want 1", mem_stall); end
    if (bus.req !== 1'b0) begin errors++; $display("FAIL rstmid_wait_req: got %b want 0", bus.req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ex_memRead = 1'b0; #1;
    vectors++;
    if (me_outMem !== 64'd0) begin errors++; $display("FAIL rstmid_out: got %h want 0", me_outMem); end
    bus.rvalid = 1'b1;
    @(negedge clk);
    bus.rvalid = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      vectors += 2;
      if (me_outMem !== 64'd0) begin errors++; $display("FAIL rstmid_stray_out: got %h want 0", me_outMem); end
      if (mem_stall !== 1'b0 || bus.req !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got stall %b req %b want 0 0", mem_stall, bus.req); end
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 60; k++) begin
      logic rd, wr, bad, w;
      logic [2:0] f3;
      logic [63:0] addr, sdata, rdata, exp_out;
      int g, r, h, n, exp_stall;
      rd = 1'($urandom % 2);
      wr = rd ? 1'($urandom % 2) : 1'b1;
      f3 = 3'($urandom % 8);
      n = 1 << f3[1:0];
      addr = {$urandom, $urandom};
      if ($urandom % 4 != 0) addr[2:0] = addr[2:0] & 3'(8 - n);
      sdata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      g = $urandom_range(0, 3); r = $urandom_range(1, 3); h = $urandom_range(0, 2);
      w = wr && !rd;
      bad = model_bad(rd, wr, f3, addr);
      exp_stall = bad ? 1 : w ? 2 + g : 2 + g + r;
      exp_out = (bad || w) ? 64'd0 : model_load(f3, addr, rdata);
      run_access(rd, wr, f3, addr, sdata, rdata, g, r, h);
      vectors += 6;
      if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", k, obs_stall, exp_stall); end
      if (obs_out !== exp_out) begin errors++; $display("FAIL rnd_out[%0d]: got %h want %h", k, obs_out, exp_out); end
      if (obs_mis !== bad) begin errors++; $display("FAIL rnd_mis[%0d]: got %b want %b", k, obs_mis, bad); end
      if (obs_req !== (bad ? 0 : g + 1)) begin errors++; $display("FAIL rnd_req[%0d]: got %0d want %0d", k, obs_req, bad ? 0 : g + 1); end
      if (obs_to !== 1'b0) begin errors++; $display("FAIL rnd_to[%0d]: got %b want 0", k, obs_to); end
      if (obs_hold_bad !== 0) begin errors++; $display("FAIL rnd_hold[%0d]: got %0d want 0", k, obs_hold_bad); end
      if (!bad) begin
        vectors += 2;
        if (obs_addr !== {addr[63:3], 3'b000}) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", k, obs_addr, {addr[63:3], 3'b000}); end
        if (obs_we !== w) begin errors++; $display("FAIL rnd_we[%0d]: got %b want %b", k, obs_we, w); end
        if (w) begin
          vectors += 2;
          if (obs_wstrb !== model_wstrb(f3, addr)) begin errors++; $display("FAIL rnd_wstrb[%0d]: got %h want %h", k, obs_wstrb, model_wstrb(f3, addr)); end
          if (obs_wdata !== model_wdata(addr, sdata)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", k, obs_wdata, model_wdata(addr, sdata)); end
        end
      end
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int st = 0;
    @(negedge clk);
    ex_memRead = 1'b1; ex_funct3 = 3'b010; ex_addr = 64'h5000; pipeline_en = 1'b0;
    repeat (40) begin
      #1;
      if (!mem_stall) break;
      st++;
      @(negedge clk);
    end
    vectors += 4;
    if (st !== 9) begin errors++; $display("FAIL to_stall: got %0d want 9", st); end
    if (me_timeout !== 1'b1) begin errors++; $display("FAIL to_flag: got %b want 1", me_timeout); end
    if (bus.req !== 1'b0) begin errors++; $display("FAIL to_req: got %b want 0", bus.req); end
    if (me_outMem !== 64'd0) begin errors++; $display("FAIL to_out: got %h want 0", me_outMem); end
    pipeline_en = 1'b1;
    @(negedge clk);
    ex_memRead = 1'b0; pipeline_en = 1'b0;
    run_access(1, 0, 3'b011, 64'h5008, '0, 64'h77, 0, 1, 0);
    vectors++;
    if (obs_to !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", obs_to); end
  endtask
`endif

  initial begin
    test_reset();
    test_lb();
    test_sh();
    test_misalign();
    test_ld_delayed();
    test_reset_midaccess();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
